// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding selects and load-use stall/bubble from a shadow EX/MEM/WB pipeline.
// Optional FWD_PERF_CNT_EN adds a saturating stall_count output.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter bit ZERO_REG_HARDWIRED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic                  flush,
  output logic [1:0]            SelFwA,
  output logic [1:0]            SelFwB,
  output logic                  stall,
  output logic                  bubble
`ifdef FWD_PERF_CNT_EN
  ,output logic [31:0]          stall_count
`endif
);
  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
    logic                  ld;
  } stg_t;

  stg_t ex_q, mem_q, wb_q, ex_d, mem_d;
  logic [1:0] sel_a_q, sel_b_q, sel_a_d, sel_b_d;

  function automatic logic hit(stg_t s, logic [REG_ADDR_W-1:0] src, logic u);
    return s.v && s.wr && s.rd == src && u && !(ZERO_REG_HARDWIRED && src == '0);
  endfunction

  always_comb begin
    stall = id_valid && !flush && ex_q.v && ex_q.ld &&
            (hit(ex_q, id_rs1, id_use_rs1) || hit(ex_q, id_rs2, id_use_rs2));
    bubble = stall || flush || !id_valid;
    ex_d = bubble ? '0 : stg_t'{v: 1'b1, rd: id_rd, wr: id_reg_write, ld: id_mem_to_reg};
    // a flush kills the instruction currently in EX, so it never reaches MEM
    mem_d = flush ? '0 : ex_q;
    sel_a_d = bubble ? 2'd0 :
              hit(ex_q, id_rs1, id_use_rs1) ? 2'd1 :
              hit(mem_q, id_rs1, id_use_rs1) ? 2'd2 :
              hit(wb_q, id_rs1, id_use_rs1) ? 2'd3 : 2'd0;
    sel_b_d = bubble ? 2'd0 :
              hit(ex_q, id_rs2, id_use_rs2) ? 2'd1 :
              hit(mem_q, id_rs2, id_use_rs2) ? 2'd2 :
              hit(wb_q, id_rs2, id_use_rs2) ? 2'd3 : 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= mem_q;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end

  assign SelFwA = sel_a_q;
  assign SelFwB = sel_b_q;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (stall && cnt_q != '1) cnt_q <= cnt_q + 32'd1;

  assign stall_count = cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and random checks against an issue-history reference model.
module tb_fwd_hazard_unit;
  logic clk = 0, rst_n = 0;
  logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_reg_write = 0, id_mem_to_reg = 0, flush = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic [1:0] SelFwA, SelFwB;
  logic stall, bubble;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_count;
  int exp_cnt = 0;
`endif
  int checks = 0, errors = 0;

  typedef struct {logic v, wr, ld; logic [4:0] rd;} ent_t;
  ent_t hist[$];

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .flush(flush),
    .SelFwA(SelFwA), .SelFwB(SelFwB), .stall(stall), .bubble(bubble)
`ifdef FWD_PERF_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // distance to the youngest issued writer of src (1 = just issued), 0 if none within 3
  function automatic logic [1:0] msel(logic [4:0] src, logic u);
    for (int d = 0; d < hist.size() && d < 3; d++)
      if (hist[d].v && hist[d].wr && hist[d].rd == src && u && src != 0) return 2'(d + 1);
    return 2'd0;
  endfunction

  function automatic logic mstall();
    return hist.size() > 0 && hist[0].v && hist[0].ld && id_valid && !flush &&
           (msel(id_rs1, id_use_rs1) == 2'd1 || msel(id_rs2, id_use_rs2) == 2'd1);
  endfunction

  task automatic drive(input logic v, input logic [4:0] r1, r2, input logic u1, u2,
                       input logic [4:0] rd, input logic wr, ld, fl);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = wr; id_mem_to_reg = ld; flush = fl;
  endtask

  task automatic cyc();
    logic es, eb;
    logic [1:0] ea, ebs;
    ent_t e;
    #1;
    es = mstall();
    eb = es || flush || !id_valid;
    chk("stall", 32'(stall), 32'(es));
    chk("bubble", 32'(bubble), 32'(eb));
    ea = eb ? 2'd0 : msel(id_rs1, id_use_rs1);
    ebs = eb ? 2'd0 : msel(id_rs2, id_use_rs2);
    e = '{v: !eb, wr: !eb && id_reg_write, ld: !eb && id_mem_to_reg, rd: eb ? 5'd0 : id_rd};
    @(posedge clk);
    if (flush && hist.size() > 0) hist[0] = '{v: 0, wr: 0, ld: 0, rd: 0};
    hist.push_front(e);
    if (hist.size() > 3) void'(hist.pop_back());
`ifdef FWD_PERF_CNT_EN
    if (es && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
`endif
    #1;
    chk("SelFwA", 32'(SelFwA), 32'(ea));
    chk("SelFwB", 32'(SelFwB), 32'(ebs));
`ifdef FWD_PERF_CNT_EN
    chk("stall_count", stall_count, exp_cnt);
`endif
    @(negedge clk);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_SelFwA", 32'(SelFwA), 0);
    chk("rst_SelFwB", 32'(SelFwB), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_bubble", 32'(bubble), 1);
    rst_n = 1;
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); cyc();
    drive(1, 5, 3, 1, 1, 10, 1, 0, 0); cyc();
    chk("alu_alu_A", 32'(SelFwA), 1);
    chk("alu_alu_B", 32'(SelFwB), 0);
    repeat (3) nop();
    for (int n = 1; n <= 3; n++) begin
      drive(1, 0, 0, 0, 0, 7, 1, 0, 0); cyc();
      repeat (n) nop();
      drive(1, 1, 7, 0, 1, 1, 0, 0, 0); cyc();
      chk("dist_B", 32'(SelFwB), n == 1 ? 2 : n == 2 ? 3 : 0);
      repeat (3) nop();
    end
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0); cyc();
    drive(1, 4, 2, 1, 1, 6, 1, 0, 0);
    #1 chk("lu_stall", 32'(stall), 1);
    cyc();
    cyc();
    chk("lu_SelFwA", 32'(SelFwA), 2);
    repeat (3) nop();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0); cyc();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0); cyc();
    drive(1, 9, 0, 1, 0, 1, 0, 0, 0); cyc();
    chk("prio_A", 32'(SelFwA), 1);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); cyc();
    drive(1, 0, 0, 1, 1, 1, 0, 0, 0); cyc();
    chk("zero_A", 32'(SelFwA), 0);
    repeat (3) nop();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0); cyc();
    drive(1, 4, 0, 1, 0, 6, 1, 0, 1);
    #1 chk("fl_stall", 32'(stall), 0);
    chk("fl_bubble", 32'(bubble), 1);
    cyc();
    drive(1, 4, 0, 1, 0, 6, 1, 0, 0); cyc();
    chk("fl_after_A", 32'(SelFwA), 0);
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0); cyc();
    drive(1, 4, 4, 1, 1, 6, 1, 0, 0);
    #1 chk("rm_stall_pre", 32'(stall), 1);
    rst_n = 0;
    #1 chk("rm_SelFwA", 32'(SelFwA), 0);
    chk("rm_SelFwB", 32'(SelFwB), 0);
    chk("rm_stall", 32'(stall), 0);
    chk("rm_bubble", 32'(bubble), 0);
    hist.delete();
`ifdef FWD_PERF_CNT_EN
    chk("rm_count", stall_count, 0);
    exp_cnt = 0;
`endif
    @(negedge clk);
    rst_n = 1;
    cyc();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0); cyc();
    drive(1, 0, 4, 0, 1, 6, 1, 0, 0); cyc();
    cyc();
    chk("post_rst_B", 32'(SelFwB), 2);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 4) != 0, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 5)), 1'($urandom),
            1'($urandom), $urandom_range(0, 9) == 0);
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
